// File: rtl/pc_fetch_stage.sv
// Fetch-stage PC register and IF/ID pipeline register for the 5-stage RV32I core.
// Handles execute-stage redirects, hazard stall/flush, and debug redirect tracking.
module pc_fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic [31:0]      InstrD,
  output logic             ValidD,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] RedirectCnt
);

  logic [XLEN-1:0] pcPlus4F;
  logic            squashD;
  logic            targetMisaligned;
  logic            cntSaturated;

  assign pcPlus4F         = PCF + XLEN'(4);
  assign squashD          = FlushD | PCSrcE;
  assign targetMisaligned = PCTargetE[1:0] != 2'b00;
  assign cntSaturated     = &RedirectCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCF         <= RESET_PC;
      PCD         <= '0;
      PCPlus4D    <= '0;
      InstrD      <= NOP_INSTR;
      ValidD      <= 1'b0;
      MisalignErr <= 1'b0;
      RedirectCnt <= '0;
    end else begin
      // A redirect beats StallF: the stalled fetch is on the wrong path anyway.
      if (PCSrcE) begin
        PCF <= {PCTargetE[XLEN-1:2], 2'b00};
      end else if (!StallF) begin
        PCF <= pcPlus4F;
      end

      // Squashed slot still captures PC info so decode-side debug sees the wrong-path PC.
      if (squashD) begin
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        InstrD   <= NOP_INSTR;
        ValidD   <= 1'b0;
      end else if (!StallD) begin
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        InstrD   <= InstrF;
        ValidD   <= 1'b1;
      end

      if (PCSrcE && targetMisaligned) begin
        MisalignErr <= 1'b1;
      end

      if (PCSrcE && !cntSaturated) begin
        RedirectCnt <= RedirectCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; imem returns PCF ^ 32'hDEAD_0000.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        MisalignErr;
  logic [15:0] RedirectCnt;

  int nCompared;
  int nMismatched;

  pc_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .MisalignErr (MisalignErr),
    .RedirectCnt (RedirectCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign InstrF = PCF ^ 32'hDEAD_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    tick();
    tick();
    nCompared++; if (PCF !== 32'h0) begin nMismatched++; $display("FAIL reset_pcf: got %h want %h", PCF, 32'h0); end
    nCompared++; if (PCD !== 32'h0) begin nMismatched++; $display("FAIL reset_pcd: got %h want %h", PCD, 32'h0); end
    nCompared++; if (PCPlus4D !== 32'h0) begin nMismatched++; $display("FAIL reset_pcplus4d: got %h want %h", PCPlus4D, 32'h0); end
    nCompared++; if (InstrD !== 32'h13) begin nMismatched++; $display("FAIL reset_instrd: got %h want %h", InstrD, 32'h13); end
    nCompared++; if (ValidD !== 1'b0) begin nMismatched++; $display("FAIL reset_validd: got %b want 0", ValidD); end
    nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL reset_misalign: got %b want 0", MisalignErr); end
    nCompared++; if (RedirectCnt !== 16'h0) begin nMismatched++; $display("FAIL reset_cnt: got %h want %h", RedirectCnt, 16'h0); end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    tick();
    nCompared++; if (PCF !== 32'h4) begin nMismatched++; $display("FAIL run1_pcf: got %h want %h", PCF, 32'h4); end
    nCompared++; if (PCD !== 32'h0) begin nMismatched++; $display("FAIL run1_pcd: got %h want %h", PCD, 32'h0); end
    nCompared++; if (PCPlus4D !== 32'h4) begin nMismatched++; $display("FAIL run1_pcplus4d: got %h want %h", PCPlus4D, 32'h4); end
    nCompared++; if (InstrD !== 32'hDEAD_0000) begin nMismatched++; $display("FAIL run1_instrd: got %h want %h", InstrD, 32'hDEAD_0000); end
    nCompared++; if (ValidD !== 1'b1) begin nMismatched++; $display("FAIL run1_validd: got %b want 1", ValidD); end
    tick();
    nCompared++; if (PCF !== 32'h8) begin nMismatched++; $display("FAIL run2_pcf: got %h want %h", PCF, 32'h8); end
    nCompared++; if (PCD !== 32'h4) begin nMismatched++; $display("FAIL run2_pcd: got %h want %h", PCD, 32'h4); end
    tick();
    nCompared++; if (PCF !== 32'hC) begin nMismatched++; $display("FAIL run3_pcf: got %h want %h", PCF, 32'hC); end
    nCompared++; if (InstrD !== 32'hDEAD_0008) begin nMismatched++; $display("FAIL run3_instrd: got %h want %h", InstrD, 32'hDEAD_0008); end
    tick();
    nCompared++; if (PCF !== 32'h10) begin nMismatched++; $display("FAIL run4_pcf: got %h want %h", PCF, 32'h10); end
  endtask

  task automatic test_redirect();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    nCompared++; if (PCF !== 32'h100) begin nMismatched++; $display("FAIL redir_pcf: got %h want %h", PCF, 32'h100); end
    nCompared++; if (InstrD !== 32'h13) begin nMismatched++; $display("FAIL redir_instrd: got %h want %h", InstrD, 32'h13); end
    nCompared++; if (ValidD !== 1'b0) begin nMismatched++; $display("FAIL redir_validd: got %b want 0", ValidD); end
    nCompared++; if (PCD !== 32'h10) begin nMismatched++; $display("FAIL redir_pcd_debug: got %h want %h", PCD, 32'h10); end
    nCompared++; if (RedirectCnt !== 16'd1) begin nMismatched++; $display("FAIL redir_cnt: got %h want %h", RedirectCnt, 16'd1); end
    tick();
    nCompared++; if (PCD !== 32'h100) begin nMismatched++; $display("FAIL redir2_pcd: got %h want %h", PCD, 32'h100); end
    nCompared++; if (ValidD !== 1'b1) begin nMismatched++; $display("FAIL redir2_validd: got %b want 1", ValidD); end
    nCompared++; if (InstrD !== 32'hDEAD_0100) begin nMismatched++; $display("FAIL redir2_instrd: got %h want %h", InstrD, 32'hDEAD_0100); end
    nCompared++; if (PCF !== 32'h104) begin nMismatched++; $display("FAIL redir2_pcf: got %h want %h", PCF, 32'h104); end
  endtask

  task automatic test_stall();
    // Reach PCF=0x20 with a valid instruction (0x1C) sitting in decode.
    PCSrcE = 1'b1; PCTargetE = 32'h18;
    tick();
    PCSrcE = 1'b0;
    tick();
    tick();
    nCompared++; if (PCF !== 32'h20) begin nMismatched++; $display("FAIL stall_pre_pcf: got %h want %h", PCF, 32'h20); end
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared++; if (PCF !== 32'h20) begin nMismatched++; $display("FAIL stall_pcf[%0d]: got %h want %h", i, PCF, 32'h20); end
      nCompared++; if (PCD !== 32'h1C) begin nMismatched++; $display("FAIL stall_pcd[%0d]: got %h want %h", i, PCD, 32'h1C); end
      nCompared++; if (InstrD !== 32'hDEAD_001C) begin nMismatched++; $display("FAIL stall_instrd[%0d]: got %h want %h", i, InstrD, 32'hDEAD_001C); end
      nCompared++; if (ValidD !== 1'b1) begin nMismatched++; $display("FAIL stall_validd[%0d]: got %b want 1", i, ValidD); end
    end
    StallF = 1'b0; StallD = 1'b0;
    tick();
    nCompared++; if (PCF !== 32'h24) begin nMismatched++; $display("FAIL stall_rel_pcf: got %h want %h", PCF, 32'h24); end
    nCompared++; if (PCD !== 32'h20) begin nMismatched++; $display("FAIL stall_rel_pcd: got %h want %h", PCD, 32'h20); end
  endtask

  task automatic test_stall_redirect();
    StallF = 1'b1; StallD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0;
    nCompared++; if (PCF !== 32'h200) begin nMismatched++; $display("FAIL stallredir_pcf: got %h want %h", PCF, 32'h200); end
    nCompared++; if (InstrD !== 32'h13) begin nMismatched++; $display("FAIL stallredir_instrd: got %h want %h", InstrD, 32'h13); end
    nCompared++; if (ValidD !== 1'b0) begin nMismatched++; $display("FAIL stallredir_validd: got %b want 0", ValidD); end
    nCompared++; if (RedirectCnt !== 16'd3) begin nMismatched++; $display("FAIL stallredir_cnt: got %h want %h", RedirectCnt, 16'd3); end
  endtask

  task automatic test_flush();
    tick();
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    nCompared++; if (PCF !== 32'h208) begin nMismatched++; $display("FAIL flush_pcf: got %h want %h", PCF, 32'h208); end
    nCompared++; if (ValidD !== 1'b0) begin nMismatched++; $display("FAIL flush_validd: got %b want 0", ValidD); end
    nCompared++; if (InstrD !== 32'h13) begin nMismatched++; $display("FAIL flush_instrd: got %h want %h", InstrD, 32'h13); end
    nCompared++; if (PCD !== 32'h204) begin nMismatched++; $display("FAIL flush_pcd: got %h want %h", PCD, 32'h204); end
  endtask

  task automatic test_misalign();
    PCSrcE = 1'b1; PCTargetE = 32'h302;
    tick();
    PCSrcE = 1'b0;
    nCompared++; if (PCF !== 32'h300) begin nMismatched++; $display("FAIL misal_pcf: got %h want %h", PCF, 32'h300); end
    nCompared++; if (MisalignErr !== 1'b1) begin nMismatched++; $display("FAIL misal_flag: got %b want 1", MisalignErr); end
    for (int i = 0; i < 10; i++) begin
      tick();
      nCompared++; if (MisalignErr !== 1'b1) begin nMismatched++; $display("FAIL misal_sticky[%0d]: got %b want 1", i, MisalignErr); end
    end
    nCompared++; if (PCF !== 32'h328) begin nMismatched++; $display("FAIL misal_run_pcf: got %h want %h", PCF, 32'h328); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL misal_clear: got %b want 0", MisalignErr); end
    nCompared++; if (RedirectCnt !== 16'd0) begin nMismatched++; $display("FAIL misal_cnt_clear: got %h want %h", RedirectCnt, 16'd0); end
  endtask

  task automatic test_saturate();
    PCSrcE = 1'b1; PCTargetE = 32'h400;
    for (int i = 0; i < 65534; i++) tick();
    nCompared++; if (RedirectCnt !== 16'hFFFE) begin nMismatched++; $display("FAIL sat_pre: got %h want %h", RedirectCnt, 16'hFFFE); end
    for (int i = 0; i < 5; i++) tick();
    PCSrcE = 1'b0;
    nCompared++; if (RedirectCnt !== 16'hFFFF) begin nMismatched++; $display("FAIL sat_cnt: got %h want %h", RedirectCnt, 16'hFFFF); end
    nCompared++; if (PCF !== 32'h400) begin nMismatched++; $display("FAIL sat_pcf: got %h want %h", PCF, 32'h400); end
    nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL sat_misal: got %b want 0", MisalignErr); end
    tick();
    nCompared++; if (RedirectCnt !== 16'hFFFF) begin nMismatched++; $display("FAIL sat_hold: got %h want %h", RedirectCnt, 16'hFFFF); end
  endtask

  task automatic test_wrap();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    nCompared++; if (PCF !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_pre_pcf: got %h want %h", PCF, 32'hFFFF_FFFC); end
    tick();
    nCompared++; if (PCF !== 32'h0) begin nMismatched++; $display("FAIL wrap_pcf: got %h want %h", PCF, 32'h0); end
    nCompared++; if (PCD !== 32'hFFFF_FFFC) begin nMismatched++; $display("FAIL wrap_pcd: got %h want %h", PCD, 32'hFFFF_FFFC); end
    nCompared++; if (PCPlus4D !== 32'h0) begin nMismatched++; $display("FAIL wrap_pcplus4d: got %h want %h", PCPlus4D, 32'h0); end
  endtask

  task automatic test_reset_override();
    rst_n = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h503; StallF = 1'b1; FlushD = 1'b1;
    tick();
    rst_n = 1'b1; PCSrcE = 1'b0; StallF = 1'b0; FlushD = 1'b0;
    nCompared++; if (PCF !== 32'h0) begin nMismatched++; $display("FAIL rstov_pcf: got %h want %h", PCF, 32'h0); end
    nCompared++; if (RedirectCnt !== 16'd0) begin nMismatched++; $display("FAIL rstov_cnt: got %h want %h", RedirectCnt, 16'd0); end
    nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL rstov_misal: got %b want 0", MisalignErr); end
    tick();
    nCompared++; if (PCF !== 32'h4) begin nMismatched++; $display("FAIL rstov_next_pcf: got %h want %h", PCF, 32'h4); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_flush();
    test_misalign();
    test_saturate();
    test_wrap();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
